// File: rtl/uart_pkg.sv
// Shared UART definitions: default line timing and the FSM state encoding
// common to the transmitter and receiver.
package uart_pkg;

  localparam int CLK_FREQ_DEF     = 24_000_000;
  localparam int BAUD_RATE_DEF    = 115_200;
  localparam int CLKS_PER_BIT_DEF = CLK_FREQ_DEF / BAUD_RATE_DEF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter with sync clear; strobes bit_done on the last cycle of a
// bit (or of a half bit when half is set, for receiver start-bit centring).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic half,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST      = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LAST = W'(CLKS_PER_BIT / 2 - 1);

  logic [W-1:0] cnt;

  assign bit_done = !clear && (cnt == (half ? HALF_LAST : LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (clear || bit_done) cnt <= '0;
    else                       cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD selects odd).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = CLK_FREQ_DEF,
  parameter int BAUD_RATE    = BAUD_RATE_DEF,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  host,
  output logic      tx,
  output logic      busy
);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t          state, state_d;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [BW-1:0]        bit_cnt, bit_cnt_d;
  logic                 tx_d;
  logic                 bit_done;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .half     (1'b0),
    .bit_done (bit_done)
  );

  assign host.ready = (state == IDLE);
  assign busy       = (state != IDLE);

`ifdef UART_TX_PARITY_EN
  logic parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            parity <= 1'b0;
    else if (state == IDLE && host.valid) parity <= (^host.data) ^ PARITY_ODD;
  end
`endif

  // tx is registered from the next-state level so the start bit appears on
  // the edge that ends the accept cycle.
  always_comb begin
    state_d   = state;
    shift_d   = shift;
    bit_cnt_d = bit_cnt;
    tx_d      = tx;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (host.valid) begin
          state_d   = START;
          shift_d   = host.data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            tx_d      = parity;
`else
            state_d   = STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
            tx_d      = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (bit_cnt == LAST_STOP) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 24 MHz / 115200 (208 clocks per bit).
module tb_uart_tx;
  localparam int CPB  = 208;
  localparam int HALF = 104;
`ifdef UART_TX_PARITY_EN
  localparam int NB    = 10;
  localparam int FRAME = 2288;
  localparam int RUN8  = 416;
`else
  localparam int NB    = 9;
  localparam int FRAME = 2080;
  localparam int RUN8  = 208;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, busy;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  uart_tx_if #(.DATA_BITS(8)) host ();

  uart_tx dut (
    .clk  (clk),
    .rst  (rst),
    .host (host),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (host.ready !== 1'b1 && n < 6000) begin tick(); n++; end
    chk("ready_timeout", 32'(n < 6000), 1);
  endtask

  task automatic send(input logic [7:0] d, output int t_acc);
    wait_ready();
    host.data  = d;
    host.valid = 1'b1;
    tick();
    host.valid = 1'b0;
    t_acc = cyc;
  endtask

  // Mid-bit sampling decoder; t0 is the first cycle the start bit is seen.
  task automatic rx_frame(output logic [7:0] b, output logic par, output logic ok, output int t0);
    int n = 0;
    while (tx !== 1'b0 && n < 6000) begin tick(); n++; end
    chk("rx_start_timeout", 32'(n < 6000), 1);
    t0 = cyc;
    repeat (HALF) tick();
    ok = (tx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = tx;
    end
    par = 1'b0;
`ifdef UART_TX_PARITY_EN
    repeat (CPB) tick();
    par = tx;
`endif
    repeat (CPB) tick();
    ok = ok && (tx === 1'b1);
  endtask

  initial begin
    int a, len, rise, lows, s1, s2;
    logic [7:0] b1, b2;
    logic p1, p2, ok1, ok2, lvl;

    host.valid = 1'b0;
    host.data  = '0;
    repeat (3) tick();
    chk("rst_tx", 32'(tx), 1);
    chk("rst_ready", 32'(host.ready), 1);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (2) tick();

    // single 0x55: alternating levels, each 208 cycles
    send(8'h55, a);
    chk("acc_tx", 32'(tx), 0);
    chk("acc_ready", 32'(host.ready), 0);
    chk("acc_busy", 32'(busy), 1);
    lvl = 1'b0;
    for (int k = 0; k < 9; k++) begin
      len = 1;
      for (int j = 0; j < 2000; j++) begin
        tick();
        if (tx !== lvl) break;
        len++;
      end
      chk($sformatf("run%0d_len", k), 32'(len), (k == 8) ? RUN8 : CPB);
      lvl = ~lvl;
    end
    chk("run_stop_lvl", 32'(tx), 1);
    wait_ready();
    rise = cyc;
    chk("frame_len", 32'(rise - a), FRAME);

    // back-to-back with valid held high
    fork
      begin
        host.data  = 8'hAA;
        host.valid = 1'b1;
        tick();
        chk("b2b_acc1_busy", 32'(busy), 1);
        host.data = 8'h0F;
        for (int j = 0; j < 6000 && host.ready !== 1'b1; j++) tick();
        tick();
        host.valid = 1'b0;
      end
      begin
        rx_frame(b1, p1, ok1, s1);
        rx_frame(b2, p2, ok2, s2);
      end
    join
    chk("b2b_byte1", 32'(b1), 32'hAA);
    chk("b2b_ok1", 32'(ok1), 1);
    chk("b2b_byte2", 32'(b2), 32'h0F);
    chk("b2b_ok2", 32'(ok2), 1);
    chk("b2b_gap", 32'(s2 - (s1 + NB * CPB)), 209);
    wait_ready();

    // write while busy must be dropped
    send(8'h55, a);
    fork
      rx_frame(b1, p1, ok1, s1);
      begin
        repeat (500) tick();
        host.data  = 8'hFF;
        host.valid = 1'b1;
        repeat (5) tick();
        chk("ign_ready", 32'(host.ready), 0);
        host.valid = 1'b0;
      end
    join
    chk("ign_byte", 32'(b1), 32'h55);
    chk("ign_ok", 32'(ok1), 1);
    wait_ready();
    lows = 0;
    repeat (400) begin tick(); if (tx !== 1'b1) lows++; end
    chk("ign_no_frame", 32'(lows), 0);

    // async reset during bit 3 of 0xA5
    send(8'hA5, a);
    repeat (CPB * 4 + 50) tick();
    chk("mid_bit3", 32'(tx), 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_tx", 32'(tx), 1);
    chk("rst_async_ready", 32'(host.ready), 1);
    chk("rst_async_busy", 32'(busy), 0);
    repeat (2) tick();
    rst = 1'b0;
    lows = 0;
    repeat (300) begin tick(); if (tx !== 1'b1) lows++; end
    chk("rst_no_resend", 32'(lows), 0);
    send(8'h3C, a);
    rx_frame(b1, p1, ok1, s1);
    chk("post_rst_byte", 32'(b1), 32'h3C);
    chk("post_rst_ok", 32'(ok1), 1);
    chk("post_rst_t0", 32'(s1), 32'(a));

`ifdef UART_TX_PARITY_EN
    wait_ready();
    send(8'h55, a);
    rx_frame(b1, p1, ok1, s1);
    chk("par55_byte", 32'(b1), 32'h55);
    chk("par55_bit", 32'(p1), 0);
    wait_ready();
    send(8'h07, a);
    rx_frame(b2, p2, ok2, s2);
    chk("par07_byte", 32'(b2), 32'h07);
    chk("par07_bit", 32'(p2), 1);
    chk("par07_ok", 32'(ok2), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter. It is the transmit-direction counterpart of the receiver in `main`, which serialises onto `tx`.
- Accepts one byte per valid/ready handshake and shifts it out LSB-first as: start bit, data bits, optional parity bit, stop bit(s).
- Sits between the top-level echo/command logic and the `tx` pin, running at 24 MHz / 115200 baud.

Parameters:
- CLK_FREQ, 24_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division, = 208), clock cycles per bit. Must be ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data  in  DATA_BITS  byte to send; sampled only on handshake.
- valid  in  1  producer has data.
- ready  out  1  transmitter can accept; high only in IDLE.
- tx  out  1  serial line, idle high, registered output.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset (async assert, sync release):
  - tx=1, ready=1, busy=0, state=IDLE.
  - Bit counter, cycle counter and shift register cleared.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - data is latched into the shift register in that cycle.
  - ready falls on the next cycle.
  - data/valid are ignored while busy; no queueing.
- Latency: tx falls (start bit) on the clock edge ending the accept cycle, i.e. one cycle after handshake.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0]; shift right every CLKS_PER_BIT cycles; exits after DATA_BITS bits.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Timing:
  - Every bit is held exactly CLKS_PER_BIT cycles.
  - Cycle counter counts 0..CLKS_PER_BIT-1 and wraps on the bit boundary.
  - Baud error (208 vs 208.33) is absorbed by the receiver; no fractional accumulation.
- Back-to-back: with valid held high, the next accept happens in the first IDLE cycle. Minimum line gap between frames = full stop period + 1 cycle.
- Reset mid-frame: tx returns high immediately; frame is abandoned; no partial retransmission.
- Widths: cycle counter is clog2(CLKS_PER_BIT) bits; bit counter is clog2(DATA_BITS+1) bits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA, lasting CLKS_PER_BIT cycles.
  - Parameter PARITY_ODD (default 0) is added.
  - Parity bit = ^data for even parity, ~^data for odd.
  - Parity is computed from the latched byte at accept.
- Undefined: no PARITY state, no PARITY_ODD parameter; frame is 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - default CLK_FREQ, BAUD_RATE, CLKS_PER_BIT;
  - FSM state encoding constants (IDLE, START, DATA, PARITY, STOP), shared with the receiver.
- One sub-module: uart_baud_gen. It holds the cycle counter with a sync clear and emits a one-cycle bit_done strobe at count CLKS_PER_BIT-1. It is reusable by the receiver (half-bit option).

Test Plan:
- Single byte:
  - Stimulus: after reset release, send 0x55.
  - Required: tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 208 cycles.
  - Frame = 2080 cycles; ready low for exactly 2080 cycles after accept.
- Back-to-back:
  - Stimulus: valid held high with 0xAA, then 0x0F.
  - Required: second start bit begins 209 cycles after the first stop bit begins.
  - Decoded stream = AA, 0F.
- Ignored write: pulse valid with 0xFF mid-frame of 0x55. Required: line carries only 0x55; ready stays 0.
- Reset mid-frame:
  - Stimulus: assert rst during bit 3 of 0xA5.
  - Required: tx=1 within the same cycle (async).
  - After release, sending 0x3C produces a clean 0x3C frame.
- Loopback: drive tx into main's rx at 115200. Required: 0x55 and 0xAA are received correctly, with no framing error.
- Parity (UART_TX_PARITY_EN, PARITY_ODD=0):
  - 0x55 → parity bit 0; 0x07 → parity bit 1.
  - Frame = 2288 cycles.
